// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial coefficient loader.
// Decoder and controller take their number format from here.
package serial_pkg;

  localparam int NUMBER_BITS_DEF  = 37;
  localparam int NUMBER_BYTES_DEF = 5;

  localparam int HDR_TGT_MSB = 7;
  localparam int HDR_TGT_LSB = 4;
  localparam int HDR_RSV_MSB = 3;
  localparam int HDR_RSV_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PAYLOAD,
    CHECK
  } load_state_t;

endpackage

// File: rtl/serial_number_decoder.sv
// Assembles NUMBER_BYTES little-endian bytes into one signed number.
// done pulses the cycle after the last byte of a number.
module serial_number_decoder
  import serial_pkg::*;
#(
  parameter int NUMBER_BITS  = NUMBER_BITS_DEF,
  parameter int NUMBER_BYTES = NUMBER_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    received_byte,
  input  logic                          received_ready,
  output logic signed [NUMBER_BITS-1:0] number,
  output logic                          done
);

  localparam int W  = NUMBER_BYTES * 8;
  localparam int CW = $clog2(NUMBER_BYTES + 1);

  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (received_ready) begin
        // newest byte enters at the top; first byte ends at the bottom
        shreg <= {received_byte, shreg[W-1:8]};
        if (cnt == CW'(NUMBER_BYTES - 1)) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign number = shreg[NUMBER_BITS-1:0];

endmodule

// File: rtl/serial_load_controller.sv
// Frame sequencer: header, count, payload coefficients, XOR check.
// Writes decoded coefficients to shadow memory; commit or error closes.
module serial_load_controller
  import serial_pkg::*;
#(
  parameter int NUMBER_BITS    = NUMBER_BITS_DEF,
  parameter int NUMBER_BYTES   = NUMBER_BYTES_DEF,
  parameter int NUM_TARGETS    = 4,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    received_byte,
  input  logic                          received_ready,
  output logic                          wr_en,
  output logic [3:0]                    wr_target,
  output logic [ADDR_BITS-1:0]          wr_addr,
  output logic signed [NUMBER_BITS-1:0] wr_data,
  output logic                          commit,
  output logic                          load_error,
  output logic                          busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  load_state_t state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [7:0]           xor_q, xor_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic [3:0]                    tgt_d;
  logic [ADDR_BITS-1:0]          addr_d;
  logic signed [NUMBER_BITS-1:0] data_d;
  logic                          wr_en_d, commit_d, err_d;

  logic                          dec_rst, dec_rdy, dec_done;
  logic signed [NUMBER_BITS-1:0] dec_number;

  logic [3:0] hdr_tgt;
  logic [3:0] hdr_rsv;
  logic       hdr_ok;
  logic       last;
  logic       timeout;

  assign hdr_tgt = received_byte[HDR_TGT_MSB:HDR_TGT_LSB];
  assign hdr_rsv = received_byte[HDR_RSV_MSB:HDR_RSV_LSB];
  assign hdr_ok  = (int'(hdr_tgt) < NUM_TARGETS) && (hdr_rsv == 4'd0);
  assign last    = (idx_q == ADDR_BITS'(count_q - 8'd1));
  assign busy    = (state_q != IDLE);
  assign timeout = busy && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  assign dec_rst = !reset || (state_q != PAYLOAD);
  assign dec_rdy = received_ready && (state_q == PAYLOAD);

  serial_number_decoder #(
    .NUMBER_BITS  (NUMBER_BITS),
    .NUMBER_BYTES (NUMBER_BYTES)
  ) u_dec (
    .clk            (clk),
    .reset          (dec_rst),
    .received_byte  (received_byte),
    .received_ready (dec_rdy),
    .number         (dec_number),
    .done           (dec_done)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    xor_d    = xor_q;
    tgt_d    = wr_target;
    addr_d   = wr_addr;
    data_d   = wr_data;
    wr_en_d  = 1'b0;
    commit_d = 1'b0;
    err_d    = 1'b0;
    timer_d  = timer_q;
    // a byte landing with the timeout is dropped
    if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (received_ready) begin
            if (hdr_ok) begin
              state_d = COUNT;
              tgt_d   = hdr_tgt;
              xor_d   = 8'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        COUNT: begin
          if (received_ready) begin
            if (received_byte != 8'd0) begin
              count_d = received_byte;
              idx_d   = '0;
              addr_d  = '0;
              state_d = PAYLOAD;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PAYLOAD: begin
          if (received_ready) xor_d = xor_q ^ received_byte;
          if (dec_done) begin
            wr_en_d = 1'b1;
            data_d  = dec_number;
            addr_d  = idx_q;
            idx_d   = idx_q + 1'b1;
            if (last) state_d = CHECK;
          end
        end
        CHECK: begin
          if (received_ready) begin
            if (received_byte == xor_q) commit_d = 1'b1;
            else                        err_d    = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end
    if (received_ready || state_d == IDLE) timer_d = '0;
    else if (busy)                         timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      timer_q    <= '0;
      wr_en      <= 1'b0;
      wr_target  <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      commit     <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      timer_q    <= timer_d;
      wr_en      <= wr_en_d;
      wr_target  <= tgt_d;
      wr_addr    <= addr_d;
      wr_data    <= data_d;
      commit     <= commit_d;
      load_error <= err_d;
    end
  end

endmodule

// File: tb/tb_serial_load_controller.sv
// Scoreboard bench for serial_load_controller.
// Frames are modelled at byte level; a monitor pops expected events.
module tb_serial_load_controller;

  localparam int NB = 37;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    received_byte = 8'd0;
  logic          received_ready = 1'b0;
  logic          wr_en;
  logic [3:0]    wr_target;
  logic [7:0]    wr_addr;
  logic signed [NB-1:0] wr_data;
  logic          commit;
  logic          load_error;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [3:0]  tgt;
    logic [7:0]  addr;
    logic [NB-1:0] data;
  } ev_t;

  ev_t exp_q[$];

  localparam int K_WR  = 0;
  localparam int K_CMT = 1;
  localparam int K_ERR = 2;

  serial_load_controller #(
    .NUMBER_BITS    (NB),
    .NUMBER_BYTES   (5),
    .NUM_TARGETS    (4),
    .ADDR_BITS      (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .received_byte  (received_byte),
    .received_ready (received_ready),
    .wr_en          (wr_en),
    .wr_target      (wr_target),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .load_error     (load_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic pop_check(input int kind, input logic [3:0] t,
                           input logic [7:0] a, input logic [NB-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d tgt=%0d addr=%0d data=%0h",
               kind, t, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind ||
          (kind == K_WR && (e.tgt !== t || e.addr !== a || e.data !== d))) begin
        errors++;
        $display("FAIL event got kind=%0d tgt=%0d addr=%0d data=%0h required kind=%0d tgt=%0d addr=%0d data=%0h",
                 kind, t, a, d, e.kind, e.tgt, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en)      pop_check(K_WR, wr_target, wr_addr, wr_data);
      if (commit)     pop_check(K_CMT, '0, '0, '0);
      if (load_error) pop_check(K_ERR, '0, '0, '0);
    end
  end

  function automatic logic [NB-1:0] model_num(input logic [7:0] b0,
      input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
      input logic [7:0] b4);
    longint v;
    v = longint'(b0) + (longint'(b1) << 8) + (longint'(b2) << 16) +
        (longint'(b3) << 24) + (longint'(b4) << 32);
    return NB'(v);
  endfunction

  function automatic ev_t mk(input int k, input logic [3:0] t,
                             input logic [7:0] a, input logic [NB-1:0] d);
    ev_t e;
    e.kind = k;
    e.tgt  = t;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    received_byte  = b;
    received_ready = 1'b1;
    @(posedge clk);
    #1;
    received_ready = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  function automatic int rgap();
    return int'($urandom_range(1, 3));
  endfunction

  // mode 0: random payload, 1: fixed nominal two-coefficient payload
  task automatic send_frame(input logic [3:0] tgt, input int cnt,
                            input bit bad_check, input bit nominal);
    logic [7:0] pl[$];
    logic [7:0] x;
    pl = {};
    x  = 8'd0;
    if (nominal)
      pl = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
    else
      for (int i = 0; i < cnt * 5; i++) pl.push_back(8'($urandom));
    foreach (pl[i]) x ^= pl[i];
    for (int c = 0; c < cnt; c++)
      exp_q.push_back(mk(K_WR, tgt, 8'(c),
        model_num(pl[5*c], pl[5*c+1], pl[5*c+2], pl[5*c+3], pl[5*c+4])));
    exp_q.push_back(mk(bad_check ? K_ERR : K_CMT, '0, '0, '0));
    send_byte({tgt, 4'h0}, rgap());
    send_byte(8'(cnt), rgap());
    foreach (pl[i]) send_byte(pl[i], rgap());
    send_byte(bad_check ? (x ^ 8'h01) : x, rgap());
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // two coefficients, values 1 and -1
    chk("model_one", 64'(model_num(8'h01, 8'h00, 8'h00, 8'h00, 8'h00)),
        64'd1);
    chk("model_minus1", 64'(model_num(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F)),
        64'h1F_FFFF_FFFF);
    send_frame(4'd2, 2, 1'b0, 1'b1);
    send_frame(4'd2, 2, 1'b1, 1'b1);

    // bad header target, reserved bits, zero count
    exp_q.push_back(mk(K_ERR, '0, '0, '0));
    send_byte(8'h50, 2);
    chk("bad_tgt_busy", 64'(busy), 64'd0);
    exp_q.push_back(mk(K_ERR, '0, '0, '0));
    send_byte(8'h01, 2);
    chk("bad_rsv_busy", 64'(busy), 64'd0);
    exp_q.push_back(mk(K_ERR, '0, '0, '0));
    send_byte(8'h20, 2);
    chk("count_busy", 64'(busy), 64'd1);
    send_byte(8'h00, 2);
    chk("zero_cnt_busy", 64'(busy), 64'd0);

    for (int f = 0; f < 8; f++)
      send_frame(4'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                 bit'($urandom_range(0, 1)), 1'b0);

    // timeout after the third payload byte
    exp_q.push_back(mk(K_ERR, '0, '0, '0));
    send_byte(8'h30, rgap());
    send_byte(8'd1, rgap());
    send_byte(8'h11, rgap());
    send_byte(8'h22, rgap());
    send_byte(8'h33, 0);
    k = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      @(posedge clk);
      #1;
      if (load_error) begin
        k = i;
        break;
      end
    end
    chk("timeout_latency", 64'(k), 64'(TO));
    chk("timeout_busy", 64'(busy), 64'd0);
    send_frame(4'd2, 2, 1'b0, 1'b1);

    // reset after the seventh payload byte of a two-coefficient frame
    exp_q.push_back(mk(K_WR, 4'd1, 8'd0,
      model_num(8'h10, 8'h20, 8'h30, 8'h40, 8'h05)));
    send_byte(8'h10, rgap());
    send_byte(8'd2, rgap());
    send_byte(8'h10, rgap());
    send_byte(8'h20, rgap());
    send_byte(8'h30, rgap());
    send_byte(8'h40, rgap());
    send_byte(8'h05, rgap());
    send_byte(8'h66, rgap());
    send_byte(8'h77, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_tgt", 64'(wr_target), 64'd0);
    chk("mid_rst_addr", 64'(wr_addr), 64'd0);
    chk("mid_rst_data", 64'(wr_data), 64'd0);
    chk("mid_rst_pulses", 64'({wr_en, commit, load_error}), 64'd0);
    send_frame(4'd3, 2, 1'b0, 1'b1);

    send_frame(4'd0, 255, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
